// File: rtl/closest_hit_scheduler_if.sv
// Bundle between the closest-hit scheduler, triangle memory, the intersection unit and the host.
// The scheduler takes the master side; its environment takes the slave side.
interface closest_hit_scheduler_if #(
    parameter int IDX_W = 16
);
    logic                     i_start;
    logic [0:1][0:2][31:0]    i_ray;
    logic [IDX_W-1:0]         i_num_tri;
    logic                     o_tri_req;
    logic [IDX_W-1:0]         o_tri_addr;
    logic                     i_tri_valid;
    logic [0:2][0:2][31:0]    i_tri_data;
    logic [0:2][0:2][31:0]    o_isect_tri;
    logic [0:1][0:2][31:0]    o_isect_ray;
    logic                     i_isect_result;
    logic                     i_isect_invalid;
    logic [31:0]              i_isect_t;
    logic [0:2][31:0]         i_isect_normal;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_hit;
    logic [IDX_W-1:0]         o_hit_idx;
    logic [31:0]              o_hit_t;
    logic [0:2][31:0]         o_hit_normal;
    logic                     o_any_invalid;

    modport master (
        input  i_start, i_ray, i_num_tri, i_tri_valid, i_tri_data,
               i_isect_result, i_isect_invalid, i_isect_t, i_isect_normal,
        output o_tri_req, o_tri_addr, o_isect_tri, o_isect_ray,
               o_busy, o_done, o_hit, o_hit_idx, o_hit_t, o_hit_normal, o_any_invalid
    );

    modport slave (
        output i_start, i_ray, i_num_tri, i_tri_valid, i_tri_data,
               i_isect_result, i_isect_invalid, i_isect_t, i_isect_normal,
        input  o_tri_req, o_tri_addr, o_isect_tri, o_isect_ray,
               o_busy, o_done, o_hit, o_hit_idx, o_hit_t, o_hit_normal, o_any_invalid
    );
endinterface

// File: rtl/closest_hit_scheduler.sv
// Walks triangles 0..N-1 for one ray, feeds the intersection unit, and keeps the closest valid hit.
// Ties on t keep the earlier triangle because the update uses a strict less-than.
module closest_hit_scheduler #(
    parameter int IDX_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    closest_hit_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [IDX_W-1:0]      num_tri_reg, num_tri_next;
    logic [0:1][0:2][31:0] ray_reg, ray_next;
    logic [0:2][0:2][31:0] tri_reg, tri_next;
    logic [31:0]           best_t_reg, best_t_next;
    logic                  hit_reg, hit_next;
    logic [IDX_W-1:0]      hit_idx_reg, hit_idx_next;
    logic [0:2][31:0]      hit_normal_reg, hit_normal_next;
    logic                  any_invalid_reg, any_invalid_next;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            num_tri_reg     <= '0;
            ray_reg         <= '0;
            tri_reg         <= '0;
            best_t_reg      <= T_MAX;
            hit_reg         <= 1'b0;
            hit_idx_reg     <= '0;
            hit_normal_reg  <= '0;
            any_invalid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            num_tri_reg     <= num_tri_next;
            ray_reg         <= ray_next;
            tri_reg         <= tri_next;
            best_t_reg      <= best_t_next;
            hit_reg         <= hit_next;
            hit_idx_reg     <= hit_idx_next;
            hit_normal_reg  <= hit_normal_next;
            any_invalid_reg <= any_invalid_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        num_tri_next     = num_tri_reg;
        ray_next         = ray_reg;
        tri_next         = tri_reg;
        best_t_next      = best_t_reg;
        hit_next         = hit_reg;
        hit_idx_next     = hit_idx_reg;
        hit_normal_next  = hit_normal_reg;
        any_invalid_next = any_invalid_reg;
        case (state_reg)
            IDLE: begin
                if (bus.i_start) begin
                    ray_next         = bus.i_ray;
                    num_tri_next     = bus.i_num_tri;
                    idx_next         = '0;
                    best_t_next      = T_MAX;
                    hit_next         = 1'b0;
                    hit_idx_next     = '0;
                    hit_normal_next  = '0;
                    any_invalid_next = 1'b0;
                    state_next       = (bus.i_num_tri == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (bus.i_tri_valid) begin
                    tri_next   = bus.i_tri_data;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                // Invalid results never compete for closest hit, even when result/t look plausible.
                if (bus.i_isect_invalid) begin
                    any_invalid_next = 1'b1;
                end else if (bus.i_isect_result &&
                             ($signed(bus.i_isect_t) < $signed(best_t_reg))) begin
                    best_t_next     = bus.i_isect_t;
                    hit_next        = 1'b1;
                    hit_idx_next    = idx_reg;
                    hit_normal_next = bus.i_isect_normal;
                end
                if (idx_reg == num_tri_reg - IDX_W'(1)) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.o_tri_req     = (state_reg == FETCH);
    assign bus.o_tri_addr    = idx_reg;
    assign bus.o_isect_tri   = tri_reg;
    assign bus.o_isect_ray   = ray_reg;
    assign bus.o_busy        = (state_reg != IDLE);
    assign bus.o_done        = (state_reg == DONE);
    assign bus.o_hit         = hit_reg;
    assign bus.o_hit_idx     = hit_idx_reg;
    assign bus.o_hit_t       = best_t_reg;
    assign bus.o_hit_normal  = hit_normal_reg;
    assign bus.o_any_invalid = any_invalid_reg;
endmodule

// File: tb/tb_closest_hit_scheduler.sv
// Randomized bench for closest_hit_scheduler: memory and intersection models, scoreboard of per-ray results.
// Triangle slot 63 is a decoy served on unsolicited valids; it would win every ray if ever latched.
module tb_closest_hit_scheduler;
    localparam int IDX_W = 16;
    localparam int JUNK  = 63;

    typedef struct {
        logic        hit;
        logic [15:0] idx;
        logic [31:0] t;
        logic [95:0] nrm;
        logic        inv;
        int          done_cyc;
        int          n;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    closest_hit_scheduler_if #(.IDX_W(IDX_W)) ifc ();
    closest_hit_scheduler #(.IDX_W(IDX_W)) dut (.i_clk(clk), .i_rstn(rstn), .bus(ifc));

    logic                  tri_res [64];
    logic                  tri_inv [64];
    logic [31:0]           tri_t   [64];
    logic [95:0]           tri_nrm [64];
    int                    tri_lat [64];
    logic [0:2][0:2][31:0] tri_mem [64];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit in_reset = 1'b1;
    bit busy_chk = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    exp_t last_e;
    logic [0:1][0:2][31:0] cur_ray;
    logic [0:2][0:2][31:0] last_data;
    int exp_addr = 0;
    int fetch_cnt = 0;
    int wait_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Purely combinational intersection model keyed by the triangle id embedded in vertex 0.
    logic [5:0] sel;
    assign sel                 = ifc.o_isect_tri[0][0][5:0];
    assign ifc.i_isect_result  = tri_res[sel];
    assign ifc.i_isect_invalid = tri_inv[sel];
    assign ifc.i_isect_t       = tri_t[sel];
    assign ifc.i_isect_normal  = tri_nrm[sel];

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_tri(input int i, input logic res, input logic inv, input logic [31:0] t, input int lat);
        tri_res[i] = res;
        tri_inv[i] = inv;
        tri_t[i]   = t;
        tri_lat[i] = lat;
        tri_nrm[i] = {$urandom(), $urandom(), $urandom()};
        tri_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
        tri_mem[i][0][0][15:0] = 16'(i);
    endtask

    task automatic model(input int n, output exp_t e);
        e.hit = 1'b0; e.idx = '0; e.t = 32'h7FFF_FFFF; e.nrm = '0; e.inv = 1'b0;
        e.n = n; e.lat = 0;
        for (int i = 0; i < n; i++) begin
            e.lat += tri_lat[i] + 2;
            if (tri_inv[i]) e.inv = 1'b1;
            else if (tri_res[i] && ($signed(tri_t[i]) < $signed(e.t))) begin
                e.hit = 1'b1; e.idx = 16'(i); e.t = tri_t[i]; e.nrm = tri_nrm[i];
            end
        end
    endtask

    // Triangle memory: per-triangle latency, address checked on every request cycle.
    always @(negedge clk) begin
        if (in_reset) begin
            ifc.i_tri_valid = 1'b0;
            exp_addr = 0; fetch_cnt = 0; wait_cnt = 0;
        end else if (ifc.o_tri_req) begin
            int a;
            a = (exp_addr > 62) ? 62 : exp_addr;
            chk("tri_addr", 288'(ifc.o_tri_addr), 288'(exp_addr));
            if (wait_cnt >= tri_lat[a]) begin
                ifc.i_tri_valid = 1'b1;
                ifc.i_tri_data  = tri_mem[a];
                last_data = tri_mem[a];
                exp_addr++; fetch_cnt++;
            end else begin
                ifc.i_tri_valid = 1'b0;
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (!ifc.o_busy) begin exp_addr = 0; fetch_cnt = 0; end
            ifc.i_tri_valid = ($urandom_range(0, 3) == 0);
            ifc.i_tri_data  = tri_mem[JUNK];
        end
    end

    // Monitor: pops the scoreboard on o_done and checks the intersection-unit feed during EVAL.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (busy_chk) begin
                chk("busy_after_done", 288'(ifc.o_busy), 288'(0));
                busy_chk = 1'b0;
            end
            if (ifc.o_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 288'(ifc.o_done), 288'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("hit",         288'(ifc.o_hit),         288'(mon_e.hit));
                    chk("hit_idx",     288'(ifc.o_hit_idx),     288'(mon_e.idx));
                    chk("hit_t",       288'(ifc.o_hit_t),       288'(mon_e.t));
                    chk("hit_normal",  288'(ifc.o_hit_normal),  288'(mon_e.nrm));
                    chk("any_invalid", 288'(ifc.o_any_invalid), 288'(mon_e.inv));
                    chk("done_cycle",  288'(cyc),               288'(mon_e.done_cyc));
                    chk("fetch_count", 288'(fetch_cnt),         288'(mon_e.n));
                    busy_chk = 1'b1;
                    $display("ray n=%0d hit=%0d idx=%0d t=%08h inv=%0d cyc=%0d",
                             mon_e.n, ifc.o_hit, ifc.o_hit_idx, ifc.o_hit_t, ifc.o_any_invalid, cyc);
                end
            end else if (ifc.o_busy && !ifc.o_tri_req) begin
                chk("isect_tri", 288'(ifc.o_isect_tri), 288'(last_data));
                chk("isect_ray", 288'(ifc.o_isect_ray), 288'(cur_ray));
            end
        end
    end

    task automatic check_reset_state();
        chk("rst_busy",    288'(ifc.o_busy),        288'(0));
        chk("rst_done",    288'(ifc.o_done),        288'(0));
        chk("rst_tri_req", 288'(ifc.o_tri_req),     288'(0));
        chk("rst_hit",     288'(ifc.o_hit),         288'(0));
        chk("rst_hit_t",   288'(ifc.o_hit_t),       288'(32'h7FFF_FFFF));
        chk("rst_idx",     288'(ifc.o_hit_idx),     288'(0));
        chk("rst_inv",     288'(ifc.o_any_invalid), 288'(0));
        chk("rst_itri",    288'(ifc.o_isect_tri),   288'(0));
        chk("rst_iray",    288'(ifc.o_isect_ray),   288'(0));
    endtask

    // Asynchronous reset pulse starting between clock edges; flushes pending expectations.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        in_reset = 1'b1;
        sb.delete();
        busy_chk = 1'b0;
        #1;
        check_reset_state();
        ifc.i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        in_reset = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic run_ray(input int n);
        exp_t e;
        bit done_seen;
        model(n, e);
        e.done_cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        cur_ray = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        ifc.i_ray     = cur_ray;
        ifc.i_num_tri = 16'(n);
        ifc.i_start   = 1'b1;
        @(negedge clk);
        done_seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (ifc.o_done) begin done_seen = 1'b1; break; end
            ifc.i_start   = ($urandom_range(0, 2) == 0);
            ifc.i_ray     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            ifc.i_num_tri = 16'($urandom_range(1, 40));
            @(negedge clk);
        end
        ifc.i_start = 1'b0;
        if (!done_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no o_done expected one within 2000 cycles (n=%0d)", n);
            do_reset();
        end else begin
            last_e = e;
            @(negedge clk);
            @(negedge clk);
            chk("hold_hit",     288'(ifc.o_hit),     288'(last_e.hit));
            chk("hold_hit_idx", 288'(ifc.o_hit_idx), 288'(last_e.idx));
            chk("hold_hit_t",   288'(ifc.o_hit_t),   288'(last_e.t));
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_tri(i, 1'b0, 1'b0, 32'h0, 0);
        tri_res[JUNK] = 1'b1;
        tri_t[JUNK]   = 32'h8000_0000;
        ifc.i_start = 1'b0;
        ifc.i_ray = '0;
        ifc.i_num_tri = '0;
        repeat (3) @(negedge clk);
        check_reset_state();
        rstn = 1'b1;
        in_reset = 1'b0;
        @(negedge clk);

        run_ray(0);

        set_tri(0, 1'b1, 1'b0, 32'h0003_0000, 0);
        set_tri(1, 1'b1, 1'b0, 32'h0001_0000, 0);
        set_tri(2, 1'b1, 1'b0, 32'h0002_0000, 0);
        run_ray(3);

        set_tri(0, 1'b0, 1'b0, 32'h0001_0000, 0);
        set_tri(1, 1'b1, 1'b0, 32'h0002_0000, 0);
        set_tri(2, 1'b1, 1'b1, 32'h0000_0000, 0);
        set_tri(3, 1'b1, 1'b0, 32'h0002_0000, 0);
        run_ray(4);

        set_tri(0, 1'b1, 1'b0, 32'h0005_0000, 2);
        set_tri(1, 1'b1, 1'b0, 32'h0004_0000, 2);
        run_ray(2);

        // Abort mid-ray while idx 2 is being fetched.
        for (int i = 0; i < 5; i++) set_tri(i, 1'b1, 1'b0, 32'h0001_0000, 0);
        cur_ray = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        ifc.i_ray = cur_ray;
        ifc.i_num_tri = 16'd5;
        ifc.i_start = 1'b1;
        @(negedge clk);
        ifc.i_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (ifc.o_tri_req && ifc.o_tri_addr == 16'd2) break;
            @(negedge clk);
        end
        chk("abort_reached_idx2", 288'(ifc.o_tri_addr), 288'(2));
        do_reset();
        repeat (10) @(negedge clk);
        run_ray(1);

        for (int i = 0; i < 5; i++) set_tri(i, 1'b0, 1'b0, 32'h0001_0000, $urandom_range(0, 1));
        run_ray(5);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++)
                set_tri(i, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                        32'(($urandom_range(0, 8) - 3) * 65536), $urandom_range(0, 3));
            run_ray(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
